// File: rtl/apb_gpio_v2_pkg.sv
// apb_gpio_v2_pkg: register offsets, interrupt-type encoding and event helper
package apb_gpio_v2_pkg;
    localparam logic [3:0] OFF_DIR    = 4'h0;
    localparam logic [3:0] OFF_IN     = 4'h1;
    localparam logic [3:0] OFF_OUT    = 4'h2;
    localparam logic [3:0] OFF_SET    = 4'h3;
    localparam logic [3:0] OFF_CLR    = 4'h4;
    localparam logic [3:0] OFF_TGL    = 4'h5;
    localparam logic [3:0] OFF_INTEN  = 4'h6;
    localparam logic [3:0] OFF_TYPE0  = 4'h7;
    localparam logic [3:0] OFF_TYPE1  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'h9;
    localparam logic [3:0] OFF_DBEN   = 4'hA;
    localparam logic [3:0] OFF_DBCNT  = 4'hB;

    localparam logic [1:0] IT_HIGH = 2'b00;
    localparam logic [1:0] IT_LOW  = 2'b01;
    localparam logic [1:0] IT_RISE = 2'b10;
    localparam logic [1:0] IT_FALL = 2'b11;

    function automatic logic int_event(input logic [1:0] t, input logic f, input logic fd);
        return t == IT_HIGH ? f :
               t == IT_LOW  ? !f :
               t == IT_RISE ? (f && !fd) :
                              (!f && fd);
    endfunction
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one pin's two-flop synchroniser and counter-based debounce filter
module gpio_debounce #(
    parameter int DB_W = 8
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            din_i,
    input  logic            db_en_i,
    input  logic [DB_W-1:0] thr_i,
    output logic            sync_o,
    output logic            filt_o
);
    logic            sync0_q, sync1_q, filt_q, filt_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // filt follows sync1 once it has differed for thr+1 cycles; counter saturates, never wraps
    always_comb begin
        filt_d = db_en_i ? ((sync1_q != filt_q && cnt_q == thr_i) ? sync1_q : filt_q) : sync1_q;
        cnt_d  = (!db_en_i || sync1_q == filt_q || cnt_q == thr_i) ? '0 :
                 (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    // synchroniser, filter and counter state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= din_i;
            sync1_q <= sync0_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync_o = sync1_q;
    assign filt_o = filt_q;
endmodule

// File: rtl/apb_gpio_v2.sv
// apb_gpio_v2: APB GPIO with atomic output ops, sticky W1C interrupts and input debounce
module apb_gpio_v2
    import apb_gpio_v2_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_GPIO       = 32,
    parameter int DB_W           = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_GPIO-1:0]       gpio_in,
    output logic [NUM_GPIO-1:0]       gpio_in_sync,
    output logic [NUM_GPIO-1:0]       gpio_out,
    output logic [NUM_GPIO-1:0]       gpio_dir,
    output logic                      interrupt
);
    logic [3:0]          off;
    logic                acc, wr;
    logic [15:0]         we;
    logic [NUM_GPIO-1:0] wdat, filt, evt;
    logic [NUM_GPIO-1:0] dir_q, dir_d, out_q, out_d, inten_q, inten_d;
    logic [NUM_GPIO-1:0] type0_q, type0_d, type1_q, type1_d;
    logic [NUM_GPIO-1:0] status_q, status_d, dben_q, dben_d, filt_dly_q;
    logic [DB_W-1:0]     dbcnt_q, dbcnt_d;
    logic                unused_bits;

    assign off  = PADDR[5:2];
    assign acc  = PSEL & PENABLE;
    assign wr   = acc & PWRITE;
    assign we   = wr ? (16'b1 << off) : '0;
    assign wdat = PWDATA[NUM_GPIO-1:0];
    assign unused_bits = ^{PADDR, PWDATA};

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
        gpio_debounce #(.DB_W(DB_W)) u_db (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .din_i   (gpio_in[i]),
            .db_en_i (dben_q[i]),
            .thr_i   (dbcnt_q),
            .sync_o  (gpio_in_sync[i]),
            .filt_o  (filt[i])
        );
        assign evt[i] = inten_q[i] & int_event({type1_q[i], type0_q[i]}, filt[i], filt_dly_q[i]);
    end

    // register next-state; a new interrupt event beats a same-cycle W1C
    always_comb begin
        dir_d    = we[OFF_DIR]   ? wdat : dir_q;
        out_d    = we[OFF_OUT]   ? wdat :
                   we[OFF_SET]   ? out_q | wdat :
                   we[OFF_CLR]   ? out_q & ~wdat :
                   we[OFF_TGL]   ? out_q ^ wdat : out_q;
        inten_d  = we[OFF_INTEN] ? wdat : inten_q;
        type0_d  = we[OFF_TYPE0] ? wdat : type0_q;
        type1_d  = we[OFF_TYPE1] ? wdat : type1_q;
        dben_d   = we[OFF_DBEN]  ? wdat : dben_q;
        dbcnt_d  = we[OFF_DBCNT] ? PWDATA[DB_W-1:0] : dbcnt_q;
        status_d = (status_q & ~(we[OFF_STATUS] ? wdat : '0)) | evt;
    end

    // combinational read mux; write-only and unmapped offsets read 0
    always_comb begin
        PRDATA = '0;
        case (off)
            OFF_DIR:    PRDATA = 32'(dir_q);
            OFF_IN:     PRDATA = 32'(filt);
            OFF_OUT:    PRDATA = 32'(out_q);
            OFF_INTEN:  PRDATA = 32'(inten_q);
            OFF_TYPE0:  PRDATA = 32'(type0_q);
            OFF_TYPE1:  PRDATA = 32'(type1_q);
            OFF_STATUS: PRDATA = 32'(status_q);
            OFF_DBEN:   PRDATA = 32'(dben_q);
            OFF_DBCNT:  PRDATA = 32'(dbcnt_q);
            default:    PRDATA = '0;
        endcase
    end

    // control/status registers and the delayed filter used for edge detection
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dir_q      <= '0;
            out_q      <= '0;
            inten_q    <= '0;
            type0_q    <= '0;
            type1_q    <= '0;
            status_q   <= '0;
            dben_q     <= '0;
            dbcnt_q    <= '0;
            filt_dly_q <= '0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            inten_q    <= inten_d;
            type0_q    <= type0_d;
            type1_q    <= type1_d;
            status_q   <= status_d;
            dben_q     <= dben_d;
            dbcnt_q    <= dbcnt_d;
            filt_dly_q <= filt;
        end
    end

    assign PREADY    = 1'b1;
    assign PSLVERR   = acc & (off > OFF_DBCNT);
    assign gpio_out  = out_q;
    assign gpio_dir  = dir_q;
    assign interrupt = |status_q;
endmodule

// File: tb/tb_apb_gpio_v2.sv
// tb_apb_gpio_v2: scoreboard bench for a 32-pin and an 8-pin apb_gpio_v2 on a shared APB bus
module tb_apb_gpio_v2;
    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
    logic [31:0] prdata, prdata8;
    logic        pready, pready8, pslverr, pslverr8, irq, irq8;
    logic [31:0] gin = '0, gsync, gout, gdir;
    logic [7:0]  gin8 = '0, gsync8, gout8, gdir8;
    int          checks = 0, errors = 0;
    logic        seen;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        bit          is8;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    apb_gpio_v2 dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .gpio_in(gin), .gpio_in_sync(gsync), .gpio_out(gout), .gpio_dir(gdir), .interrupt(irq)
    );

    apb_gpio_v2 #(.NUM_GPIO(8)) dut8 (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(pslverr8),
        .gpio_in(gin8), .gpio_in_sync(gsync8), .gpio_out(gout8), .gpio_dir(gdir8), .interrupt(irq8)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [11:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(posedge HCLK) #1;
        PENABLE = 1'b1;
        @(posedge HCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] addr, input logic [31:0] exp, input logic err,
                          input bit is8, input string tag);
        sb.push_back('{tag, exp, err, is8});
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        @(posedge HCLK) #1;
        PENABLE = 1'b1;
        @(posedge HCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic edge_n();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    always @(negedge HCLK) begin
        if (PSEL && PENABLE && !PWRITE) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk(e.tag, e.is8 ? prdata8 : prdata, e.data);
                chk({e.tag, "_err"}, {31'b0, e.is8 ? pslverr8 : pslverr}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge HCLK);
        chk("rst_out", gout, 0);
        chk("rst_dir", gdir, 0);
        chk("rst_sync", gsync, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_pready", {31'b0, pready}, 1);
        HRESETn = 1'b1;
        for (int i = 0; i < 12; i++) apb_rd(12'(i * 4), 32'h0, 1'b0, 0, $sformatf("rst_rd%0d", i));
        apb_rd(12'h030, 32'h0, 1'b1, 0, "unmapped30");

        apb_wr(12'h008, 32'h0000_00F0);
        apb_wr(12'h00C, 32'h0000_0001);
        apb_wr(12'h010, 32'h0000_0010);
        apb_wr(12'h014, 32'h0000_0101);
        @(negedge HCLK);
        chk("out_atomic", gout, 32'h0000_01E0);
        chk("out8_atomic", {24'b0, gout8}, 32'h0000_00E0);
        apb_rd(12'h008, 32'h0000_01E0, 1'b0, 0, "out_rd");
        apb_rd(12'h00C, 32'h0, 1'b0, 0, "set_rd0");
        apb_rd(12'h03C, 32'h0, 1'b1, 0, "unmapped3c");
        apb_wr(12'h000, 32'hA5A5_0F0F);
        @(negedge HCLK);
        chk("dir", gdir, 32'hA5A5_0F0F);

        apb_wr(12'h018, 32'h8);
        apb_wr(12'h020, 32'h8);
        apb_wr(12'h01C, 32'h0);
        PADDR = 12'h004;
        @(posedge HCLK) #1;
        gin[3] = 1'b1;
        edge_n();
        chk("sync_e1", gsync, 0);
        edge_n();
        chk("sync_e2", gsync, 32'h8);
        chk("in_e2", prdata, 0);
        edge_n();
        chk("in_e3", prdata, 32'h8);
        chk("irq_e3", {31'b0, irq}, 0);
        edge_n();
        chk("irq_e4", {31'b0, irq}, 1);
        apb_rd(12'h024, 32'h8, 1'b0, 0, "status_rise");
        apb_wr(12'h024, 32'h8);
        @(negedge HCLK);
        chk("irq_w1c", {31'b0, irq}, 0);

        apb_wr(12'h028, 32'h1);
        apb_wr(12'h02C, 32'h5);
        PADDR = 12'h004;
        @(posedge HCLK) #1;
        gin[0] = 1'b1;
        repeat (3) @(posedge HCLK) #1;
        gin[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge HCLK);
            seen = seen | prdata[0];
        end
        chk("db_pulse", {31'b0, seen}, 0);
        @(posedge HCLK) #1;
        gin[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            edge_n();
            chk($sformatf("db_hold_e%0d", k), {31'b0, prdata[0]}, {31'b0, k >= 8});
        end

        apb_wr(12'h01C, 32'h2);
        apb_wr(12'h018, 32'h2);
        apb_rd(12'h024, 32'h2, 1'b0, 0, "lvl_set");
        apb_wr(12'h024, 32'h2);
        apb_rd(12'h024, 32'h2, 1'b0, 0, "lvl_w1c_held");
        chk("lvl_irq", {31'b0, irq}, 1);
        apb_wr(12'h018, 32'h0);
        apb_rd(12'h024, 32'h2, 1'b0, 0, "lvl_sticky");
        apb_wr(12'h024, 32'h2);
        apb_rd(12'h024, 32'h0, 1'b0, 0, "lvl_cleared");
        chk("lvl_irq_off", {31'b0, irq}, 0);

        apb_wr(12'h008, 32'hFFFF_FFFF);
        apb_rd(12'h008, 32'h0000_00FF, 1'b0, 1, "n8_out");
        apb_rd(12'h008, 32'hFFFF_FFFF, 1'b0, 0, "n32_out");
        chk("n8_pins", {24'b0, gout8}, 32'h0000_00FF);
        apb_wr(12'h02C, 32'hFFFF_FFFF);
        apb_rd(12'h02C, 32'h0000_00FF, 1'b0, 1, "n8_dbcnt");

        apb_wr(12'h028, 32'h4);
        apb_wr(12'h02C, 32'h5);
        PADDR = 12'h004;
        @(posedge HCLK) #1;
        gin8[2] = 1'b1;
        repeat (4) @(posedge HCLK);
        @(negedge HCLK);
        chk("pre_rst_sync8", {24'b0, gsync8}, 32'h4);
        chk("pre_rst_in8", prdata8, 0);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_sync8", {24'b0, gsync8}, 0);
        chk("arst_in8", prdata8, 0);
        chk("arst_in", prdata, 0);
        chk("arst_out", gout, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        apb_rd(12'h028, 32'h0, 1'b0, 1, "arst_dben8");
        apb_rd(12'h02C, 32'h0, 1'b0, 1, "arst_dbcnt8");

        @(negedge HCLK);
        chk("sb_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
